// File: rtl/main_control_pipe.sv
// Main control decoder feeding a registered control-word pipeline, with a
// two-micro-op CALL sequencer and a sticky illegal-opcode flag.
//
//  state | meaning
//  ------+--------------------------------------------------------------
//  DEC   | normal decode of the ID instruction
//  LINK  | CALL uop1 issued; uop2 (link write) pending, ID frozen
module main_control_pipe #(
   parameter int OP_W   = 4,
   parameter int FUNC_W = 3,
   parameter int NSTAGE = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [OP_W-1:0]       op,
   input  logic [FUNC_W-1:0]     func,
   input  logic                  stall,
   input  logic                  flush,
   output logic                  id_hold,
   output logic [NSTAGE*9-1:0]   stage_ctrl,
   output logic [NSTAGE-1:0]     stage_valid,
   output logic                  illegal
);

   localparam logic [31:0] OP_R    = 32'd0;
   localparam logic [31:0] OP_ANDI = 32'd1;
   localparam logic [31:0] OP_ADDI = 32'd2;
   localparam logic [31:0] OP_LW   = 32'd3;
   localparam logic [31:0] OP_SW   = 32'd4;
   localparam logic [31:0] OP_BEQ  = 32'd5;
   localparam logic [31:0] OP_BNE  = 32'd6;
   localparam logic [31:0] OP_FOR  = 32'd7;

   // {Call,For,RegDst,RegWr,ExtOp,ALUSrc,MemRd,MemWr,WBdata}
   localparam logic [8:0] UOP1 = 9'b100000000;
   localparam logic [8:0] UOP2 = 9'b100100000;

   typedef enum logic {DEC, LINK} state_t;

   state_t                state, nxt_state;
   logic [31:0]           op_x, func_x;
   logic [8:0]            dec_word, s0_ctrl;
   logic                  is_call, is_ill, s0_valid, set_ill;
   logic [NSTAGE*9-1:0]   ctrl_q;
   logic [NSTAGE-1:0]     valid_q;

   assign op_x   = 32'(op);
   assign func_x = 32'(func);

   always_comb begin
      dec_word = '0;
      is_call  = 1'b0;
      is_ill   = 1'b0;
      case (op_x)
         OP_R:    dec_word = 9'b001100000;
         OP_ANDI: dec_word = 9'b000101000;
         OP_ADDI: dec_word = 9'b000111000;
         OP_LW:   dec_word = 9'b000111101;
         OP_SW:   dec_word = 9'b000011010;
         OP_BEQ:  dec_word = 9'b000010000;
         OP_BNE:  dec_word = 9'b000010000;
         OP_FOR:  dec_word = 9'b010100000;
         default: begin
            if (func_x == 32'd1)      is_call = 1'b1;
            else if (func_x != 32'd0) is_ill  = 1'b1;
         end
      endcase
   end

   always_comb begin
      nxt_state = state;
      s0_ctrl   = '0;
      s0_valid  = 1'b0;
      set_ill   = 1'b0;
      case (state)
         DEC: begin
            if (id_valid && !stall && !flush) begin
               s0_valid = 1'b1;
               if (is_call) begin
                  s0_ctrl   = UOP1;
                  nxt_state = LINK;
               end else begin
                  s0_ctrl = dec_word;
                  set_ill = is_ill;
               end
            end
         end
         LINK: begin
            // A flush abandons the link write; uop1 is already in flight.
            if (flush) begin
               nxt_state = DEC;
            end else if (!stall) begin
               s0_ctrl   = UOP2;
               s0_valid  = 1'b1;
               nxt_state = DEC;
            end
         end
         default: nxt_state = DEC;
      endcase
   end

   assign id_hold = (state == LINK);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= DEC;
         illegal <= 1'b0;
      end else begin
         state   <= nxt_state;
         illegal <= illegal | set_ill;
      end
   end

   generate
      if (NSTAGE > 1) begin : g_multi
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               ctrl_q  <= '0;
               valid_q <= '0;
            end else begin
               ctrl_q  <= {ctrl_q[(NSTAGE-1)*9-1:0], s0_ctrl};
               valid_q <= {valid_q[NSTAGE-2:0], s0_valid};
            end
         end
      end else begin : g_single
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               ctrl_q  <= '0;
               valid_q <= '0;
            end else begin
               ctrl_q  <= s0_ctrl;
               valid_q <= s0_valid;
            end
         end
      end
   endgenerate

   assign stage_ctrl  = ctrl_q;
   assign stage_valid = valid_q;

endmodule

// File: tb/tb_main_control_pipe.sv
// Self-checking bench for main_control_pipe: directed scenarios plus a random
// stream compared against a behavioural model of the decode table and pipeline.
module tb_main_control_pipe;

   localparam int NS = 3;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              id_valid = 1'b0;
   logic [3:0]        op = '0;
   logic [2:0]        func = '0;
   logic              stall = 1'b0;
   logic              flush = 1'b0;
   logic              id_hold;
   logic [NS*9-1:0]   stage_ctrl;
   logic [NS-1:0]     stage_valid;
   logic              illegal;

   int n_checks = 0;
   int n_errors = 0;

   logic [8:0] m_ctrl [NS];
   logic       m_valid [NS];
   bit         m_ill;
   bit         m_link;

   main_control_pipe #(.OP_W(4), .FUNC_W(3), .NSTAGE(NS)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .op(op), .func(func),
      .stall(stall), .flush(flush), .id_hold(id_hold), .stage_ctrl(stage_ctrl),
      .stage_valid(stage_valid), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Decode table: opcode numbering R=0,ANDI=1,ADDI=2,LW=3,SW=4,BEQ=5,BNE=6,FOR=7.
   task automatic spec_decode(input int o, input int f, output logic [8:0] w,
                              output bit call, output bit ill);
      w = '0; call = 0; ill = 0;
      if (o == 0)      w = 9'b001100000;
      else if (o == 1) w = 9'b000101000;
      else if (o == 2) w = 9'b000111000;
      else if (o == 3) w = 9'b000111101;
      else if (o == 4) w = 9'b000011010;
      else if (o == 5 || o == 6) w = 9'b000010000;
      else if (o == 7) w = 9'b010100000;
      else if (f == 1) call = 1;
      else if (f != 0) ill = 1;
   endtask

   function automatic logic [NS*9-1:0] exp_ctrl();
      logic [NS*9-1:0] v;
      for (int k = 0; k < NS; k++) v[k*9 +: 9] = m_ctrl[k];
      return v;
   endfunction

   function automatic logic [NS-1:0] exp_valid();
      logic [NS-1:0] v;
      for (int k = 0; k < NS; k++) v[k] = m_valid[k];
      return v;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < NS; k++) begin
         m_ctrl[k] = '0;
         m_valid[k] = 1'b0;
      end
      m_ill = 0;
      m_link = 0;
   endtask

   // Advance model by one clock using current inputs, then clock the DUT.
   task automatic tick();
      logic [8:0] w0, dw;
      bit v0, c, il;
      w0 = '0; v0 = 0;
      if (flush) m_link = 0;
      else if (stall) v0 = 0;
      else if (m_link) begin
         w0 = 9'b100100000; v0 = 1; m_link = 0;
      end else if (id_valid) begin
         spec_decode(int'(op), int'(func), dw, c, il);
         v0 = 1;
         if (c) begin
            w0 = 9'b100000000; m_link = 1;
         end else begin
            w0 = dw;
            if (il) m_ill = 1;
         end
      end
      for (int k = NS - 1; k > 0; k--) begin
         m_ctrl[k] = m_ctrl[k-1];
         m_valid[k] = m_valid[k-1];
      end
      m_ctrl[0] = w0;
      m_valid[0] = v0;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input int o, input int f, input bit s, input bit fl);
      id_valid = v; op = 4'(o); func = 3'(f); stall = s; flush = fl;
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      reset = 1'b1;
      drive(0, 0, 0, 0, 0);
      model_clear();
      #2;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (stage_ctrl !== '0 || stage_valid !== '0 || illegal !== 1'b0 || id_hold !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_state ctrl=%h valid=%b ill=%b hold=%b required all zero",
                  stage_ctrl, stage_valid, illegal, id_hold);
      end
      drive(1, 3, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0); tick();
      n_checks++;
      if (stage_ctrl[9 +: 9] !== 9'b000111101 || stage_valid !== 3'b010) begin
         n_errors++;
         $display("FAIL reset_lw_in_s1 s1=%b valid=%b required 000111101 010",
                  stage_ctrl[9 +: 9], stage_valid);
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (stage_ctrl !== '0 || stage_valid !== '0 || illegal !== 1'b0 || id_hold !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_async ctrl=%h valid=%b ill=%b required zero before edge",
                  stage_ctrl, stage_valid, illegal);
      end
      model_clear();
      #1 reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_stream();
      drive(1, 0, 0, 0, 0); tick();
      n_checks++;
      if (stage_ctrl[8:0] !== 9'b001100000 || stage_valid[0] !== 1'b1) begin
         n_errors++;
         $display("FAIL stream_rtype s0=%b v=%b required 001100000 1", stage_ctrl[8:0], stage_valid[0]);
      end
      drive(1, 3, 0, 0, 0); tick();
      drive(1, 4, 0, 0, 0); tick();
      n_checks++;
      if (stage_ctrl[18 +: 9] !== 9'b001100000 || stage_ctrl[8:0] !== 9'b000011010 ||
          stage_valid !== 3'b111) begin
         n_errors++;
         $display("FAIL stream_sw s2=%b s0=%b valid=%b required 001100000 000011010 111",
                  stage_ctrl[18 +: 9], stage_ctrl[8:0], stage_valid);
      end
      n_checks++;
      if (stage_ctrl !== exp_ctrl()) begin
         n_errors++;
         $display("FAIL stream_model ctrl=%h required %h", stage_ctrl, exp_ctrl());
      end
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic test_stall();
      for (int i = 0; i < 2; i++) begin
         drive(1, 2, 0, 1, 0); tick();
         n_checks++;
         if (stage_valid[0] !== 1'b0 || stage_ctrl[8:0] !== 9'b0) begin
            n_errors++;
            $display("FAIL stall_bubble%0d s0=%b v=%b required 0 0", i, stage_ctrl[8:0], stage_valid[0]);
         end
      end
      drive(1, 2, 0, 0, 0); tick();
      n_checks++;
      if (stage_ctrl[8:0] !== 9'b000111000 || stage_valid !== 3'b001) begin
         n_errors++;
         $display("FAIL stall_release s0=%b valid=%b required 000111000 001",
                  stage_ctrl[8:0], stage_valid);
      end
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic test_call();
      drive(1, 9, 1, 0, 0); tick();
      n_checks++;
      if (stage_ctrl[8:0] !== 9'b100000000 || id_hold !== 1'b1) begin
         n_errors++;
         $display("FAIL call_uop1 s0=%b hold=%b required 100000000 1", stage_ctrl[8:0], id_hold);
      end
      drive(1, 3, 0, 0, 0); tick();
      n_checks++;
      if (stage_ctrl[8:0] !== 9'b100100000 || stage_valid[1:0] !== 2'b11 || id_hold !== 1'b0) begin
         n_errors++;
         $display("FAIL call_uop2 s0=%b v=%b hold=%b required 100100000 11 0",
                  stage_ctrl[8:0], stage_valid[1:0], id_hold);
      end
      drive(1, 9, 1, 0, 0); tick();
      drive(1, 9, 1, 0, 1); tick();
      n_checks++;
      if (stage_valid[0] !== 1'b0 || id_hold !== 1'b0 || stage_ctrl[17:9] !== 9'b100000000) begin
         n_errors++;
         $display("FAIL call_flush s0v=%b hold=%b s1=%b required 0 0 100000000",
                  stage_valid[0], id_hold, stage_ctrl[17:9]);
      end
      drive(0, 0, 0, 0, 0); tick();
      n_checks++;
      if (stage_ctrl !== exp_ctrl() || stage_valid !== 3'b100) begin
         n_errors++;
         $display("FAIL call_no_uop2 ctrl=%h valid=%b required %h 100", stage_ctrl, stage_valid, exp_ctrl());
      end
   endtask

   task automatic test_illegal();
      do_reset();
      drive(1, 12, 5, 1, 0); tick();
      n_checks++;
      if (illegal !== 1'b0) begin
         n_errors++;
         $display("FAIL illegal_stalled ill=%b required 0", illegal);
      end
      drive(1, 12, 5, 0, 0); tick();
      n_checks++;
      if (illegal !== 1'b1 || stage_ctrl[8:0] !== 9'b0 || stage_valid[0] !== 1'b1) begin
         n_errors++;
         $display("FAIL illegal_set ill=%b s0=%b v=%b required 1 0 1", illegal, stage_ctrl[8:0], stage_valid[0]);
      end
      drive(1, 0, 0, 0, 0); tick(); tick();
      n_checks++;
      if (illegal !== 1'b1) begin
         n_errors++;
         $display("FAIL illegal_sticky ill=%b required 1", illegal);
      end
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic test_flush_stall();
      do_reset();
      drive(1, 7, 0, 1, 1); tick();
      n_checks++;
      if (stage_valid[0] !== 1'b0 || stage_ctrl[8:0] !== 9'b0 || id_hold !== 1'b0) begin
         n_errors++;
         $display("FAIL flush_stall s0=%b v=%b hold=%b required 0 0 0", stage_ctrl[8:0], stage_valid[0], id_hold);
      end
      drive(1, 7, 0, 0, 0); tick();
      n_checks++;
      if (stage_ctrl[8:0] !== 9'b010100000 || stage_valid[0] !== 1'b1) begin
         n_errors++;
         $display("FAIL for_after s0=%b v=%b required 010100000 1", stage_ctrl[8:0], stage_valid[0]);
      end
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic test_random();
      int errs_here;
      errs_here = 0;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 15),
               ($urandom_range(0, 2) == 0) ? 1 : $urandom_range(0, 7),
               $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
         tick();
         n_checks++;
         if (stage_ctrl !== exp_ctrl() || stage_valid !== exp_valid() ||
             illegal !== m_ill || id_hold !== m_link) begin
            n_errors++;
            if (errs_here < 5)
               $display("FAIL random_%0d ctrl=%h valid=%b ill=%b hold=%b required %h %b %b %b",
                        i, stage_ctrl, stage_valid, illegal, id_hold,
                        exp_ctrl(), exp_valid(), m_ill, m_link);
            errs_here++;
         end
      end
      drive(0, 0, 0, 0, 0);
   endtask

   initial begin
      model_clear();
      test_reset();
      test_stream();
      test_stall();
      test_call();
      test_illegal();
      test_flush_stall();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
